// File: rtl/sd_cmd_rx_pkg.sv
// Shared definitions for the SPI-mode SD command receiver: frame geometry,
// CRC7 polynomial and single-step helper, DataOut byte-select codes, FSM states.
// Latency: n/a (package). Backpressure: n/a (package).
package sd_cmd_rx_pkg;

    // A command frame is always 48 bits; only the first 40 are covered by CRC7.
    localparam int FRAME_BITS = 48;
    localparam int CRC_BITS   = 40;

    // x^7 + x^3 + 1 with the x^7 term implied.
    localparam logic [6:0] CRC7_POLY = 7'h09;

    // DataOut byte selects.
    localparam logic [2:0] RD_IDX  = 3'd0;  // {start, tx, index[5:0]}
    localparam logic [2:0] RD_ARG3 = 3'd1;  // arg[31:24]
    localparam logic [2:0] RD_ARG2 = 3'd2;  // arg[23:16]
    localparam logic [2:0] RD_ARG1 = 3'd3;  // arg[15:8]
    localparam logic [2:0] RD_ARG0 = 3'd4;  // arg[7:0]
    localparam logic [2:0] RD_CRC  = 3'd5;  // {crc7, end}
    localparam logic [2:0] RD_STAT = 3'd6;  // {5'b0, overrun, frame_err, crc_err}
    localparam logic [2:0] RD_ZERO = 3'd7;  // reads as zero

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // One serial CRC7 step, MSB-first input.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1, init 0), one bit per enabled clock, MSB first.
// Latency: crc_o reflects a bit one clock after it is presented with en_i.
// Backpressure: none; caller gates en_i. clr_i with en_i restarts on the current bit.
//
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  async active-low reset
//   clr_i   restart the remainder from zero
//   en_i    absorb din_i this clock
//   din_i   serial data bit
//   crc_o   current remainder
module sd_crc7
    import sd_cmd_rx_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       din_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;
    logic [6:0] crc_base;

    always_comb begin
        // Clear and enable together means the current bit is the first bit of a new message.
        crc_base = clr_i ? 7'h00 : crc_q;
        crc_d    = crc_q;
        if (en_i) begin
            crc_d = crc7_step(crc_base, din_i);
        end else if (clr_i) begin
            crc_d = 7'h00;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= 7'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_cmd_rx.sv
// SPI-mode SD command receiver: deserialises 48-bit frames on SCLK, checks framing and CRC7, holds result.
// Latency: frame is held (cmd_rdy_n_o low) on the same edge that samples its last bit.
// Backpressure: held frame blocks new commits until ack_n_i; a frame arriving meanwhile is dropped and flags overrun.
//
// Ports:
//   sclk_i        sole clock, rising edge
//   reset_n_i     async active-low reset
//   cs_n_i        card select, active low; high during a frame aborts it
//   di_i          serial data, MSB first
//   ack_n_i       release of the held frame, active low, sampled on sclk_i
//   rd_sel_i      byte select for data_out_o
//   data_out_o    selected byte of held frame / status
//   cmd_rdy_n_o   low while a valid frame is held
//   busy_o        high while a frame is being shifted in
//   crc_err_o     CRC7 of held frame bad
//   frame_err_o   transmit or end bit of held frame is 0
//   overrun_o     sticky: a frame started while one was held
module sd_cmd_rx
    import sd_cmd_rx_pkg::*;
#(
    parameter int DWIDTH    = 8,
    parameter bit CRC_CHECK = 1'b1
) (
    input  logic              sclk_i,
    input  logic              reset_n_i,
    input  logic              cs_n_i,
    input  logic              di_i,
    input  logic              ack_n_i,
    input  logic [2:0]        rd_sel_i,
    output logic [DWIDTH-1:0] data_out_o,
    output logic              cmd_rdy_n_o,
    output logic              busy_o,
    output logic              crc_err_o,
    output logic              frame_err_o,
    output logic              overrun_o
);

    state_e state_q, state_d;

    // Shift register holds bits 47..1 once the last bit is on di_i; bit 0 never needs storing.
    logic [FRAME_BITS-2:0] sh_q,   sh_d;
    logic [FRAME_BITS-1:0] hold_q, hold_d;
    logic [5:0]            cnt_q,  cnt_d;
    logic                  crc_err_q,   crc_err_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q,   overrun_d;
    // Set while a frame that arrived during HOLD is being swallowed.
    logic                  drop_q,      drop_d;

    logic                  crc_clr;
    logic                  crc_en;
    logic [6:0]            crc_w;

    logic                  start_bit;
    logic                  last_bit;
    logic                  start_en;
    logic                  shift_en;
    logic                  commit;
    logic [FRAME_BITS-1:0] frame_nxt;
    logic [7:0]            rd_byte;

    assign start_bit = ~cs_n_i & ~di_i;
    assign last_bit  = (cnt_q == 6'(FRAME_BITS - 1));
    assign frame_nxt = {sh_q, di_i};

    sd_crc7 u_crc7 (
        .clk_i  (sclk_i),
        .rst_ni (reset_n_i),
        .clr_i  (crc_clr),
        .en_i   (crc_en),
        .din_i  (di_i),
        .crc_o  (crc_w)
    );

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        crc_err_d   = crc_err_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        drop_d      = drop_q;
        crc_clr     = 1'b0;
        crc_en      = 1'b0;
        start_en    = 1'b0;
        shift_en    = 1'b0;
        commit      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // di_i high with cs_n_i low is idle fill, not a start.
                if (start_bit) begin
                    start_en = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cs_n_i) begin
                    // Abort: partial frame discarded, status of previous frame left alone.
                    state_d = ST_IDLE;
                end else begin
                    shift_en = 1'b1;
                    if (last_bit) begin
                        commit  = 1'b1;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!ack_n_i) begin
                    // Release wins over everything; a coincident start bit begins a clean frame.
                    crc_err_d   = 1'b0;
                    frame_err_d = 1'b0;
                    overrun_d   = 1'b0;
                    drop_d      = 1'b0;
                    if (start_bit) begin
                        start_en = 1'b1;
                        state_d  = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (drop_q) begin
                    if (cs_n_i) begin
                        drop_d = 1'b0;
                    end else begin
                        shift_en = 1'b1;
                        if (last_bit) begin
                            drop_d = 1'b0;
                        end
                    end
                end else if (start_bit) begin
                    start_en  = 1'b1;
                    drop_d    = 1'b1;
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_en) begin
            sh_d    = {sh_q[FRAME_BITS-3:0], di_i};
            cnt_d   = 6'd1;
            crc_clr = 1'b1;
            crc_en  = 1'b1;
        end

        if (shift_en) begin
            sh_d   = {sh_q[FRAME_BITS-3:0], di_i};
            cnt_d  = cnt_q + 6'd1;
            // cnt_q is the number of bits already taken; CRC covers the first 40.
            crc_en = (cnt_q < 6'(CRC_BITS));
        end

        if (commit) begin
            hold_d      = frame_nxt;
            crc_err_d   = CRC_CHECK && (crc_w != frame_nxt[7:1]);
            frame_err_d = ~frame_nxt[FRAME_BITS-2] | ~frame_nxt[0];
        end
    end

    always_ff @(posedge sclk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            sh_q        <= '0;
            hold_q      <= '0;
            cnt_q       <= 6'd0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            crc_err_q   <= crc_err_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            drop_q      <= drop_d;
        end
    end

    // Read mux over held registers.
    always_comb begin
        rd_byte = 8'h00;
        unique case (rd_sel_i)
            RD_IDX:  rd_byte = hold_q[47:40];
            RD_ARG3: rd_byte = hold_q[39:32];
            RD_ARG2: rd_byte = hold_q[31:24];
            RD_ARG1: rd_byte = hold_q[23:16];
            RD_ARG0: rd_byte = hold_q[15:8];
            RD_CRC:  rd_byte = hold_q[7:0];
            RD_STAT: rd_byte = {5'b00000, overrun_q, frame_err_q, crc_err_q};
            RD_ZERO: rd_byte = 8'h00;
            default: rd_byte = 8'h00;
        endcase
    end

    assign data_out_o  = DWIDTH'(rd_byte);
    assign cmd_rdy_n_o = (state_q != ST_HOLD);
    assign busy_o      = (state_q == ST_SHIFT) | drop_q;
    assign crc_err_o   = crc_err_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_sd_cmd_rx.sv
// Bench for sd_cmd_rx: directed and random frames, scoreboard of expected held frames,
// monitor reads every byte select whenever a frame is presented or a re-read is requested.
// Two instances run in parallel: CRC checking on and off.
module tb_sd_cmd_rx;

    logic       clk;
    logic       rst_n;
    logic       cs_n;
    logic       di;
    logic       ack_n;
    logic [2:0] rd_sel;
    logic [7:0] dout0, dout1;
    logic       rdy0, busy0, ce0, fe0, ov0;
    logic       rdy1, busy1, ce1, fe1, ov1;

    int n_checks = 0;
    int n_fail   = 0;
    int req_cnt  = 0;
    int served_cnt = 0;

    typedef struct {
        logic [47:0] frame;
        logic        ce;
        logic        fe;
        logic        ov;
    } exp_t;

    exp_t sb[$];

    sd_cmd_rx #(.DWIDTH(8), .CRC_CHECK(1'b1)) dut0 (
        .sclk_i(clk), .reset_n_i(rst_n), .cs_n_i(cs_n), .di_i(di), .ack_n_i(ack_n),
        .rd_sel_i(rd_sel), .data_out_o(dout0), .cmd_rdy_n_o(rdy0), .busy_o(busy0),
        .crc_err_o(ce0), .frame_err_o(fe0), .overrun_o(ov0)
    );

    sd_cmd_rx #(.DWIDTH(8), .CRC_CHECK(1'b0)) dut1 (
        .sclk_i(clk), .reset_n_i(rst_n), .cs_n_i(cs_n), .di_i(di), .ack_n_i(ack_n),
        .rd_sel_i(rd_sel), .data_out_o(dout1), .cmd_rdy_n_o(rdy1), .busy_o(busy1),
        .crc_err_o(ce1), .frame_err_o(fe1), .overrun_o(ov1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CRC7 by polynomial long division of msg * x^7 by x^7+x^3+1.
    function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
        logic [46:0] r;
        r = {msg, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic exp_t model(input logic [47:0] f, input logic ov);
        exp_t e;
        e.frame = f;
        e.ce    = (f[7:1] != crc7_ref(f[47:8]));
        e.fe    = !f[46] || !f[0];
        e.ov    = ov;
        return e;
    endfunction

    function automatic logic [47:0] mk(input logic tx, input logic [5:0] idx, input logic [31:0] arg,
                                       input logic good, input logic endb);
        logic [39:0] body;
        logic [6:0]  c;
        body = {1'b0, tx, idx, arg};
        c    = crc7_ref(body);
        if (!good) c = c ^ 7'h15;
        return {body, c, endb};
    endfunction

    function automatic void check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: on each newly presented frame (or a requested re-read) pop and compare everything.
    initial begin : monitor
        logic  prev_rdy;
        exp_t  e;
        logic [7:0] eb0, eb1;
        rd_sel   = 3'd0;
        prev_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if ((prev_rdy && !rdy0) || (req_cnt != served_cnt)) begin
                if (req_cnt != served_cnt) served_cnt++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame: DUT presented a frame, scoreboard empty");
                end else begin
                    e = sb.pop_front();
                    for (int s = 0; s < 8; s++) begin
                        rd_sel = 3'(s);
                        #1;
                        if (s < 6) begin
                            eb0 = e.frame[47 - 8*s -: 8];
                            eb1 = eb0;
                        end else if (s == 6) begin
                            eb0 = {5'b0, e.ov, e.fe, e.ce};
                            eb1 = {5'b0, e.ov, e.fe, 1'b0};
                        end else begin
                            eb0 = 8'h00;
                            eb1 = 8'h00;
                        end
                        check($sformatf("dout_crcon_sel%0d", s), dout0, eb0);
                        check($sformatf("dout_crcoff_sel%0d", s), dout1, eb1);
                    end
                    check("crc_err", ce0, e.ce);
                    check("frame_err", fe0, e.fe);
                    check("overrun", ov0, e.ov);
                    check("crc_err_crcoff", ce1, 1'b0);
                    check("busy_at_present", busy0, 1'b0);
                    check("rdy_crcoff", rdy1, 1'b0);
                end
            end
            prev_rdy = rdy0;
        end
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        cs_n = 1'b0;
        di   = b;
    endtask

    task automatic idle(input int n, input logic csn);
        repeat (n) begin
            @(negedge clk);
            cs_n = csn;
            di   = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) send_bit(f[i]);
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack_n = 1'b0;
        cs_n  = 1'b0;
        di    = 1'b1;
        @(negedge clk);
        ack_n = 1'b1;
    endtask

    task automatic expect_released(input string tag);
        check({tag, "_rdy_n"}, rdy0, 1'b1);
        check({tag, "_ovr_clr"}, ov0, 1'b0);
        check({tag, "_crc_clr"}, ce0, 1'b0);
        check({tag, "_frm_clr"}, fe0, 1'b0);
    endtask

    task automatic expect_reset(input string tag);
        check({tag, "_rdy_n"}, rdy0, 1'b1);
        check({tag, "_busy"}, busy0, 1'b0);
        check({tag, "_crc"}, ce0, 1'b0);
        check({tag, "_frm"}, fe0, 1'b0);
        check({tag, "_ovr"}, ov0, 1'b0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not reach the end, limit 400000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [47:0] f, fb;
        rst_n = 1'b0;
        cs_n  = 1'b1;
        di    = 1'b1;
        ack_n = 1'b1;
        #12;
        expect_reset("reset");
        check("reset_dout", dout0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, 1'b1);

        // CMD0
        f = 48'h40_0000_0000_95;
        sb.push_back(model(f, 1'b0));
        send_frame(f);
        idle(2, 1'b0);
        do_ack();
        expect_released("cmd0");

        // CMD8 good, then bad CRC
        f = 48'h48_0000_01AA_87;
        sb.push_back(model(f, 1'b0));
        send_frame(f);
        idle(2, 1'b1);
        do_ack();
        expect_released("cmd8");
        f = 48'h48_0000_01AA_85;
        sb.push_back(model(f, 1'b0));
        send_frame(f);
        idle(2, 1'b0);
        do_ack();
        expect_released("cmd8_badcrc");

        // CMD0 with end bit 0
        f = 48'h40_0000_0000_94;
        sb.push_back(model(f, 1'b0));
        send_frame(f);
        idle(2, 1'b0);
        do_ack();
        expect_released("cmd0_endbit");

        // Abort after 20 bits, then a full frame
        f = mk(1'b1, 6'h11, 32'h1234_5678, 1'b1, 1'b1);
        for (int i = 47; i >= 28; i--) send_bit(f[i]);
        @(posedge clk);
        #1;
        check("abort_busy_before", busy0, 1'b1);
        @(negedge clk);
        cs_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy_after", busy0, 1'b0);
        check("abort_rdy_n", rdy0, 1'b1);
        idle(3, 1'b1);
        sb.push_back(model(f, 1'b0));
        send_frame(f);
        idle(2, 1'b0);
        do_ack();
        expect_released("after_abort");

        // Overrun: second frame while first held
        f  = mk(1'b1, 6'h12, 32'hCAFE_F00D, 1'b1, 1'b1);
        fb = mk(1'b1, 6'h2D, 32'h0BAD_BEEF, 1'b1, 1'b1);
        sb.push_back(model(f, 1'b0));
        send_frame(f);
        idle(2, 1'b0);
        send_bit(fb[47]);
        @(posedge clk);
        #1;
        check("ovr_set", ov0, 1'b1);
        check("ovr_busy", busy0, 1'b1);
        check("ovr_rdy_n", rdy0, 1'b0);
        for (int i = 46; i >= 0; i--) send_bit(fb[i]);
        @(posedge clk);
        #1;
        sb.push_back(model(f, 1'b1));
        req_cnt++;
        idle(4, 1'b0);
        do_ack();
        expect_released("ovr_ack");

        // Ack coincident with start bit of the next frame
        f  = mk(1'b1, 6'h08, 32'h0000_01AA, 1'b1, 1'b1);
        fb = mk(1'b1, 6'h37, 32'h8000_0001, 1'b1, 1'b1);
        sb.push_back(model(f, 1'b0));
        send_frame(f);
        idle(2, 1'b0);
        sb.push_back(model(fb, 1'b0));
        @(negedge clk);
        ack_n = 1'b0;
        cs_n  = 1'b0;
        di    = fb[47];
        @(negedge clk);
        ack_n = 1'b1;
        di    = fb[46];
        for (int i = 45; i >= 0; i--) send_bit(fb[i]);
        idle(2, 1'b0);
        do_ack();
        expect_released("ack_start");

        // Random frames
        for (int n = 0; n < 24; n++) begin
            f = mk(($urandom_range(0, 7) != 0), 6'($urandom_range(0, 63)), 32'($urandom),
                   ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0));
            idle($urandom_range(0, 3), 1'($urandom_range(0, 1)));
            sb.push_back(model(f, 1'b0));
            send_frame(f);
            idle(2, 1'b0);
            do_ack();
            expect_released($sformatf("rand%0d", n));
        end

        // Reset while holding
        f = mk(1'b1, 6'h05, 32'h5555_AAAA, 1'b0, 1'b0);
        sb.push_back(model(f, 1'b0));
        send_frame(f);
        idle(2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_reset("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while shifting
        f = mk(1'b1, 6'h19, 32'h0F0F_0F0F, 1'b1, 1'b1);
        for (int i = 47; i >= 38; i--) send_bit(f[i]);
        @(posedge clk);
        #1;
        check("rst_shift_busy_before", busy0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        expect_reset("rst_shift");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, 1'b1);
        sb.push_back(model(f, 1'b0));
        send_frame(f);
        idle(2, 1'b0);
        do_ack();
        expect_released("after_reset");

        // Drain scoreboard with a bounded wait
        for (int k = 0; k < 200 && (sb.size() != 0 || req_cnt != served_cnt); k++) @(posedge clk);
        check("scoreboard_drained", 48'(sb.size()), 48'd0);
        idle(2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
